// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: boot address, bubble word, state encoding, instruction width.
package cpu_defs;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [INST_W-1:0] DEF_NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: redirect, then pending redirect, then sequential pc+4.
// Purely combinational; redirect targets are word-aligned and misalignment is flagged.
module pc_next_sel
    import cpu_defs::*;
(
    input  logic [INST_W-1:0] pc,
    input  logic              br_valid,
    input  logic [INST_W-1:0] br_target,
    input  logic              pend_valid,
    input  logic [INST_W-1:0] pend_target,
    output logic [INST_W-1:0] next_pc,
    output logic [INST_W-1:0] tgt_aligned,
    output logic              misaligned
);

    always_comb begin
        tgt_aligned = {br_target[INST_W-1:2], 2'b00};
        misaligned  = br_valid && (br_target[1:0] != 2'b00);
        next_pc     = pc + 32'd4;
        if (br_valid) begin
            next_pc = tgt_aligned;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the combinational imem port, fills IF/ID one edge later.
// Stall freezes PC and IF/ID (redirects are parked); flush overrides stall and inserts a bubble.
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INST_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_valid,
    input  logic [INST_W-1:0] br_target,
    output logic              ce,
    output logic [INST_W-1:0] addr,
    input  logic [INST_W-1:0] data,
    output logic [INST_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic              adel_err
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] pc_q;
    logic              pend_valid_q;
    logic [INST_W-1:0] pend_target_q;
    logic [INST_W-1:0] next_pc;
    logic [INST_W-1:0] tgt_aligned;
    logic              misaligned;
    logic              advance;

    pc_next_sel u_pc_next_sel (
        .pc          (pc_q),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .pend_valid  (pend_valid_q),
        .pend_target (pend_target_q),
        .next_pc     (next_pc),
        .tgt_aligned (tgt_aligned),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ce      = 1'b0;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN:  ce      = 1'b1;
            default:    state_d = FETCH_BOOT;
        endcase
    end

    // Flush wins over stall: the pipe must keep moving to reach the exception vector.
    assign advance = (state_q == FETCH_RUN) && (flush || !stall);
    assign addr    = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            if_pc         <= '0;
            if_inst       <= NOP_WORD;
            if_valid      <= 1'b0;
            adel_err      <= 1'b0;
        end else begin
            if (misaligned) begin
                adel_err <= 1'b1;
            end
            if (advance) begin
                // A live redirect supersedes any parked one, so the park slot always empties here.
                pc_q         <= next_pc;
                pend_valid_q <= 1'b0;
                if_pc        <= pc_q;
                if (flush) begin
                    if_inst  <= NOP_WORD;
                    if_valid <= 1'b0;
                end else begin
                    if_inst  <= data;
                    if_valid <= 1'b1;
                end
            end else if (br_valid) begin
                pend_target_q <= tgt_aligned;
                pend_valid_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, sequential fetch, stall, delay-slot redirect, flush, wrap, reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, br_valid;
    logic [31:0] br_target;

    logic        ce, if_valid, adel_err;
    logic [31:0] addr, data, if_pc, if_inst;
    logic        ce_b, if_valid_b, adel_err_b;
    logic [31:0] addr_b, data_b, if_pc_b, if_inst_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h2400_0000 ^ {a[15:0], a[17:2]};
    endfunction

    assign data   = memword(addr);
    assign data_b = memword(addr_b);

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_target(br_target),
        .ce(ce), .addr(addr), .data(data),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .adel_err(adel_err)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_target(br_target),
        .ce(ce_b), .addr(addr_b), .data(data_b),
        .if_pc(if_pc_b), .if_inst(if_inst_b), .if_valid(if_valid_b), .adel_err(adel_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_valid = 1'b0; br_target = '0;
        #12;
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_adel", 32'(adel_err), 32'd0);
        check("b_rst_addr", addr_b, 32'hFFFF_FFFC);

        step(); rst_n = 1'b1;
        check("boot_ce", 32'(ce), 32'd0);
        step();
        check("run_ce", 32'(ce), 32'd1);
        check("run_addr0", addr, 32'h0);
        check("run_valid0", 32'(if_valid), 32'd0);
        check("b_addr_boot", addr_b, 32'hFFFF_FFFC);
        step();
        check("seq0_pc", if_pc, 32'h0);
        check("seq0_inst", if_inst, memword(32'h0));
        check("seq0_valid", 32'(if_valid), 32'd1);
        check("b_wrap_addr", addr_b, 32'h0);
        check("b_wrap_if_pc", if_pc_b, 32'hFFFF_FFFC);
        step();
        check("seq1_pc", if_pc, 32'h4);
        check("seq1_inst", if_inst, memword(32'h4));
        step();
        check("seq2_pc", if_pc, 32'h8);
        check("seq2_inst", if_inst, memword(32'h8));
        step();
        check("pre_stall_addr", addr, 32'h10);

        // Stall three cycles at pc=0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", addr, 32'h10);
            check("stall_if_pc", if_pc, 32'hC);
            check("stall_if_inst", if_inst, memword(32'hC));
        end
        stall = 1'b0;
        step();
        check("unstall_if_pc", if_pc, 32'h10);
        check("unstall_if_inst", if_inst, memword(32'h10));

        // Redirect with delay slot at pc=0x24
        for (int i = 0; i < 4; i++) step();
        check("br_pre_addr", addr, 32'h24);
        br_valid = 1'b1; br_target = 32'h40;
        step();
        br_valid = 1'b0;
        check("dslot_if_pc", if_pc, 32'h24);
        check("dslot_inst", if_inst, memword(32'h24));
        check("br_addr", addr, 32'h40);
        step();
        check("br_tgt_if_pc", if_pc, 32'h40);

        // Redirect parked during stall
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h80;
        step();
        br_valid = 1'b0;
        check("pend_addr0", addr, 32'h44);
        for (int i = 0; i < 2; i++) begin
            step();
            check("pend_addr_hold", addr, 32'h44);
            check("pend_if_pc_hold", if_pc, 32'h40);
        end
        stall = 1'b0;
        step();
        check("pend_cap_pc", if_pc, 32'h44);
        check("pend_apply_addr", addr, 32'h80);
        step();
        check("pend_tgt_if_pc", if_pc, 32'h80);

        // Flush overrides stall
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        check("flush_valid", 32'(if_valid), 32'd0);
        check("flush_inst", if_inst, 32'h0);
        check("flush_if_pc", if_pc, 32'h84);
        check("flush_addr", addr, 32'h88);

        // Misaligned redirect
        br_valid = 1'b1; br_target = 32'h43;
        step();
        br_valid = 1'b0;
        check("mis_addr", addr, 32'h40);
        check("mis_adel", 32'(adel_err), 32'd1);
        check("mis_valid", 32'(if_valid), 32'd1);
        step();
        check("adel_sticky", 32'(adel_err), 32'd1);
        check("mis_seq_addr", addr, 32'h44);

        // Reset while a redirect is parked
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h200;
        step();
        br_valid = 1'b0; stall = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_addr", addr, 32'h0);
        check("midrst_adel", 32'(adel_err), 32'd0);
        check("midrst_valid", 32'(if_valid), 32'd0);
        step(); rst_n = 1'b1;
        step();
        step();
        check("pend_lost_addr", addr, 32'h4);

        // Redirect arriving in BOOT is applied at the first RUN edge
        rst_n = 1'b0; #1;
        step(); rst_n = 1'b1;
        br_valid = 1'b1; br_target = 32'h100;
        step();
        br_valid = 1'b0;
        check("boot_br_addr", addr, 32'h0);
        step();
        check("boot_br_apply", addr, 32'h100);
        check("boot_br_if_pc", if_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage for the single-issue MIPS core. It owns the PC and drives the combinational instruction memory port (ce, addr → data). Each cycle it captures the returned word into the IF/ID register. It handles pipeline stall, flush, and branch/jump redirect, with MIPS delay-slot semantics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (boot address).
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or bubble.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard unit hold; freezes PC and IF/ID.
flush  input  1  squash IF/ID contents (exception/eret path).
br_valid  input  1  redirect request from ID stage, single-cycle pulse.
br_target  input  32  redirect target address.
ce  output  1  instruction memory chip enable.
addr  output  32  instruction memory byte address (= PC).
data  input  32  instruction word from memory, same-cycle combinational.
if_pc  output  32  PC of the instruction held in IF/ID.
if_inst  output  32  instruction held in IF/ID.
if_valid  output  1  IF/ID holds a real instruction.
adel_err  output  1  sticky flag: misaligned redirect target seen.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=BOOT, ce=0, if_pc=0, if_inst=NOP_WORD, if_valid=0, pend_valid=0, adel_err=0.
- States:
  - BOOT: ce=0, no capture. Next edge → RUN. This gives one cycle of settle after reset release.
  - RUN: ce=1.
- addr = pc, combinational, in every state. pc[1:0] is always 00.
- RUN, stall=0, flush=0, at the edge:
  - if_pc←pc, if_inst←data, if_valid←1.
  - pc←next_pc.
- next_pc priority:
  1. br_valid → br_target.
  2. pend_valid → pend_target, and pend_valid←0.
  3. Otherwise pc+4, 32-bit wrap (0xFFFFFFFC → 0x00000000).
- Delay slot: a branch resolved in ID while IF fetches the next word keeps that word. The delay slot is never squashed by br_valid.
- stall=1 (flush=0):
  - pc and IF/ID hold.
  - If br_valid=1 in the same cycle: pend_target←br_target, pend_valid←1.
  - The pending target is applied on the first non-stalled RUN edge. A newer br_valid during stall overwrites it.
- flush=1 (highest priority, overrides stall):
  - if_inst←NOP_WORD, if_valid←0, if_pc←pc.
  - pc advances per next_pc rules; pend_valid is consumed normally.
- Misaligned target (br_target[1:0]≠0): the target is aligned down (low bits cleared) and adel_err←1. adel_err stays set until reset.
- br_valid in BOOT: latched into the pending register and applied on the first RUN edge.
- Reset mid-operation: all state returns to reset values immediately. Any pending redirect is discarded.
- Latency: an instruction at pc appears on if_inst one edge after it is presented on addr. A redirect at edge N gives addr=target after edge N.

Decomposition:
- Shared package cpu_defs holds:
  - RESET_PC default.
  - NOP_WORD.
  - FETCH_BOOT/FETCH_RUN state encoding.
  - Instruction-width constant INST_W=32.
- One natural sub-module, pc_next_sel: combinational next-PC priority mux with alignment check. Everything else stays in inst_fetch.

Test Plan:
1. Reset, release rst_n → ce=0 for 1 cycle, addr=0x0. Then ce=1 and if_inst sequence equals mem[0], mem[1], mem[2] with if_pc 0x0, 0x4, 0x8.
2. stall=1 for 3 cycles at pc=0x10 → addr stays 0x10, if_inst/if_pc unchanged. After release, next capture has if_pc=0x10.
3. br_valid=1, br_target=0x40 while pc=0x24 → if_pc 0x24 (delay slot) captured, then addr=0x40 on the next cycle.
4. br_valid with target 0x80 during stall, stall held 2 more cycles → addr holds. After stall drops: one capture at the held pc, then addr=0x80.
5. flush=1 with stall=1 → if_valid=0, if_inst=0x00000000, pc advances by 4. br_target=0x43 → addr=0x40 and adel_err=1 remains set.
6. RESET_PC=0xFFFFFFFC, run two cycles → addr 0xFFFFFFFC then 0x00000000. Assert rst_n=0 mid-pending-redirect → pending lost, addr=RESET_PC.
